// File: rtl/display_feed_pkg.sv
// Shared definitions for the retirement display feed: FSM states and opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package def;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    LIVE   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  // Opcode shown on the display before anything has retired.
  localparam logic [7:0] NOP = 8'h00;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low push-button to a single-cycle press pulse (2-FF sync + stability counter).
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse.
// Backpressure: none; a press is one pulse per accepted high-to-low level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_s2_n,
  input  logic key_n,
  output logic pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-stage synchronizer; resets to the released (high) level.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      level   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      pressed <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level   <= sync2;
        cnt     <= '0;
        pressed <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_feed.sv
// Retired-instruction history buffer with OFF/LIVE/FROZEN display control from three keys.
// Latency: op_code/r16 update one cycle after a cpu_valid write; key actions after debounce.
// Backpressure: none; retirements arriving while frozen are dropped and flagged in lost.
module display_feed
  import def::*;
#(
  parameter int DEPTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_s2_n,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_op_code,
  input  logic [7:0] cpu_r16,
  input  logic       key_disp_n,
  input  logic       key_hold_n,
  input  logic       key_step_n,
  output logic       enable,
  output logic [7:0] op_code,
  output logic [7:0] r16,
  output logic       frozen,
  output logic [3:0] hist_index,
  output logic       lost
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic disp_press;
  logic hold_press;
  logic step_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_disp (
    .clock      (clock),
    .reset_s2_n (reset_s2_n),
    .key_n      (key_disp_n),
    .pressed    (disp_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_hold (
    .clock      (clock),
    .reset_s2_n (reset_s2_n),
    .key_n      (key_hold_n),
    .pressed    (hold_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
    .clock      (clock),
    .reset_s2_n (reset_s2_n),
    .key_n      (key_step_n),
    .pressed    (step_press)
  );

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_ptr_nxt;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_nxt;
  logic [3:0]      hist_nxt;
  logic            lost_nxt;
  logic            do_write;
  logic [AW-1:0]   rd_addr;
  logic [15:0]     rd_data;
  logic [15:0]     mem [DEPTH];

  // Next state, buffer bookkeeping and display read address. The write is
  // resolved before the key action so a freeze in the same cycle sees it.
  always_comb begin
    state_nxt  = state;
    hist_nxt   = hist_index;
    lost_nxt   = lost;
    do_write   = cpu_valid && (state != FROZEN);
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;

    if (do_write) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
      if (count != CNTW'(DEPTH)) begin
        count_nxt = count + 1'b1;
      end
    end

    // Priority disp > hold > step falls out of the if/else chains.
    case (state)
      OFF: begin
        if (disp_press) begin
          state_nxt = LIVE;
        end
      end
      LIVE: begin
        if (disp_press) begin
          state_nxt = OFF;
        end else if (hold_press && (count_nxt != '0)) begin
          state_nxt = FROZEN;
          hist_nxt  = 4'd0;
        end
      end
      FROZEN: begin
        if (disp_press) begin
          state_nxt = OFF;
          hist_nxt  = 4'd0;
        end else if (hold_press) begin
          state_nxt = LIVE;
          hist_nxt  = 4'd0;
        end else if (step_press) begin
          hist_nxt = (hist_index == 4'(count - CNTW'(1))) ? 4'd0 : hist_index + 4'd1;
        end
      end
      default: begin
        state_nxt = OFF;
        hist_nxt  = 4'd0;
      end
    endcase

    if ((state == FROZEN) && cpu_valid) begin
      lost_nxt = 1'b1;
    end
    if ((state != LIVE) && (state_nxt == LIVE)) begin
      lost_nxt = 1'b0;
    end

    // Entry shown is (wr_ptr - 1 - hist_index) mod DEPTH on the post-update
    // values; a same-cycle write to that slot is forwarded.
    rd_addr = wr_ptr_nxt - AW'(1) - hist_nxt[AW-1:0];
    if (do_write && (rd_addr == wr_ptr)) begin
      rd_data = {cpu_op_code, cpu_r16};
    end else begin
      rd_data = mem[rd_addr];
    end
  end

  // History storage; contents are don't-care until counted in.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr] <= {cpu_op_code, cpu_r16};
    end
  end

  // State, pointers and registered display outputs.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      state      <= OFF;
      wr_ptr     <= '0;
      count      <= '0;
      hist_index <= 4'd0;
      lost       <= 1'b0;
      enable     <= 1'b0;
      frozen     <= 1'b0;
      op_code    <= NOP;
      r16        <= 8'h00;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      hist_index <= hist_nxt;
      lost       <= lost_nxt;
      enable     <= (state_nxt != OFF);
      frozen     <= (state_nxt == FROZEN);
      if (count_nxt != '0) begin
        op_code <= rd_data[15:8];
        r16     <= rd_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_display_feed.sv
// Directed self-checking bench for display_feed with short debounce.
// Latency: checks sampled on the falling edge after each stimulus step.
// Backpressure: n/a.
module tb_display_feed;

  localparam logic [7:0] LDI    = 8'hE0;
  localparam logic [7:0] NOP_TB = 8'h00;

  logic       clock = 1'b0;
  logic       reset_s2_n;
  logic       cpu_valid;
  logic [7:0] cpu_op_code;
  logic [7:0] cpu_r16;
  logic       key_disp_n;
  logic       key_hold_n;
  logic       key_step_n;
  logic       enable;
  logic [7:0] op_code;
  logic [7:0] r16;
  logic       frozen;
  logic [3:0] hist_index;
  logic       lost;

  int tests = 0;
  int fails = 0;
  int disp_pulses = 0;
  int pulses_before;

  display_feed #(.DEPTH(8), .DEBOUNCE_CYCLES(4)) u_dut (
    .clock       (clock),
    .reset_s2_n  (reset_s2_n),
    .cpu_valid   (cpu_valid),
    .cpu_op_code (cpu_op_code),
    .cpu_r16     (cpu_r16),
    .key_disp_n  (key_disp_n),
    .key_hold_n  (key_hold_n),
    .key_step_n  (key_step_n),
    .enable      (enable),
    .op_code     (op_code),
    .r16         (r16),
    .frozen      (frozen),
    .hist_index  (hist_index),
    .lost        (lost)
  );

  always #10 clock = ~clock;

  always @(posedge clock) begin
    if (u_dut.u_key_disp.pressed === 1'b1) disp_pulses++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_key(input int which, input logic v);
    case (which)
      0: key_disp_n = v;
      1: key_hold_n = v;
      default: key_step_n = v;
    endcase
  endtask

  // Clean press: low long enough to debounce, then released long enough to settle.
  task automatic press(input int which);
    set_key(which, 1'b0);
    repeat (12) @(negedge clock);
    set_key(which, 1'b1);
    repeat (12) @(negedge clock);
  endtask

  task automatic retire(input logic [7:0] op, input logic [7:0] r);
    cpu_valid   = 1'b1;
    cpu_op_code = op;
    cpu_r16     = r;
    @(negedge clock);
    cpu_valid   = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_enable"}, 16'(enable), 16'd0);
    check({pfx, "_op_code"}, 16'(op_code), 16'(NOP_TB));
    check({pfx, "_r16"}, 16'(r16), 16'h00);
    check({pfx, "_frozen"}, 16'(frozen), 16'd0);
    check({pfx, "_hist_index"}, 16'(hist_index), 16'd0);
    check({pfx, "_lost"}, 16'(lost), 16'd0);
  endtask

  initial begin
    reset_s2_n  = 1'b0;
    cpu_valid   = 1'b0;
    cpu_op_code = 8'h00;
    cpu_r16     = 8'h00;
    key_disp_n  = 1'b1;
    key_hold_n  = 1'b1;
    key_step_n  = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset_s2_n = 1'b1;
    repeat (2) @(negedge clock);

    // Display on, then a single retirement appears one cycle later.
    press(0);
    check("on_enable", 16'(enable), 16'd1);
    check("on_frozen", 16'(frozen), 16'd0);
    retire(LDI, 8'h02);
    check("ldi_op_code", 16'(op_code), 16'(LDI));
    check("ldi_r16", 16'(r16), 16'h02);

    // Bouncy press and release of disp: exactly one toggle (LIVE -> OFF).
    pulses_before = disp_pulses;
    key_disp_n = 1'b0; repeat (2) @(negedge clock);
    key_disp_n = 1'b1; repeat (2) @(negedge clock);
    key_disp_n = 1'b0; repeat (2) @(negedge clock);
    key_disp_n = 1'b1; repeat (2) @(negedge clock);
    key_disp_n = 1'b0; repeat (20) @(negedge clock);
    key_disp_n = 1'b1; repeat (2) @(negedge clock);
    key_disp_n = 1'b0; repeat (2) @(negedge clock);
    key_disp_n = 1'b1; repeat (20) @(negedge clock);
    check("bounce_pulses", 16'(disp_pulses - pulses_before), 16'd1);
    check("bounce_enable", 16'(enable), 16'd0);
    check("off_tracks_r16", 16'(r16), 16'h02);
    press(0);
    check("relive_enable", 16'(enable), 16'd1);

    // Ten retirements overflow the 8-entry history; newest is 0x0A.
    for (int i = 1; i <= 10; i++) begin
      retire(8'h10 + 8'(i), 8'(i));
    end
    check("fill_r16", 16'(r16), 16'h0A);
    press(1);
    check("freeze_frozen", 16'(frozen), 16'd1);
    check("freeze_hist", 16'(hist_index), 16'd0);
    check("freeze_r16", 16'(r16), 16'h0A);
    for (int s = 1; s <= 8; s++) begin
      press(2);
      check($sformatf("step%0d_hist", s), 16'(hist_index), 16'(s % 8));
      check($sformatf("step%0d_r16", s), 16'(r16), 16'(10 - (s % 8)));
      check($sformatf("step%0d_op", s), 16'(op_code), 16'(8'h10 + 8'(10 - (s % 8))));
    end

    // Retirement while frozen is dropped and flagged; unfreezing clears the flag.
    retire(8'h30, 8'h55);
    check("drop_lost", 16'(lost), 16'd1);
    check("drop_r16", 16'(r16), 16'h0A);
    press(1);
    check("thaw_frozen", 16'(frozen), 16'd0);
    check("thaw_lost", 16'(lost), 16'd0);
    check("thaw_enable", 16'(enable), 16'd1);
    check("thaw_r16", 16'(r16), 16'h0A);
    check("thaw_op", 16'(op_code), 16'h1A);

    // Retirement lands in the same cycle as the hold pulse (pulse on the 7th edge).
    key_hold_n = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    retire(8'h40, 8'h77);
    check("coin_frozen", 16'(frozen), 16'd1);
    check("coin_hist", 16'(hist_index), 16'd0);
    check("coin_r16", 16'(r16), 16'h77);
    check("coin_lost", 16'(lost), 16'd0);
    repeat (10) @(negedge clock);
    key_hold_n = 1'b1;
    repeat (12) @(negedge clock);

    // Three steps back: 0x77, 0x0A, 0x09, 0x08.
    press(2);
    press(2);
    press(2);
    check("back3_hist", 16'(hist_index), 16'd3);
    check("back3_r16", 16'(r16), 16'h08);
    check("back3_op", 16'(op_code), 16'h18);

    // Asynchronous reset between clock edges.
    #3 reset_s2_n = 1'b0;
    #1 check_reset_values("arst");
    @(negedge clock);
    reset_s2_n = 1'b1;
    repeat (2) @(negedge clock);

    // After reset the buffer is empty: hold in LIVE is ignored.
    press(0);
    check("post_enable", 16'(enable), 16'd1);
    press(1);
    check("empty_hold_frozen", 16'(frozen), 16'd0);
    check("empty_op_code", 16'(op_code), 16'(NOP_TB));
    check("empty_r16", 16'(r16), 16'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_feed.md
DISPLAY_FEED -- requirements
Module: display_feed

Interface
REQ-001 Parameter DEPTH, default 8, is the number of history entries; it SHALL be a power of two, 2..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), is the number of stable cycles required to accept a key level.
REQ-003 clock  input  1  50 MHz system clock.
REQ-004 reset_s2_n  input  1  synchronized reset; asynchronous, active-low.
REQ-005 cpu_valid  input  1  one-cycle pulse when the CPU retires an instruction.
REQ-006 cpu_op_code  input  8  OP code of the retired instruction; valid with cpu_valid.
REQ-007 cpu_r16  input  8  R16 contents after retirement; valid with cpu_valid.
REQ-008 key_disp_n  input  1  raw push-button, active-low; toggles display on/off.
REQ-009 key_hold_n  input  1  raw push-button, active-low; toggles freeze.
REQ-010 key_step_n  input  1  raw push-button, active-low; steps back through history while frozen.
REQ-011 enable  output  1  display enable.
REQ-012 op_code  output  8  OP code to display.
REQ-013 r16  output  8  R16 value to display.
REQ-014 frozen  output  1  high in FROZEN state.
REQ-015 hist_index  output  4  age of the displayed entry; 0 = newest.
REQ-016 lost  output  1  sticky flag: a retirement was dropped while frozen.

Function
REQ-017 Each key SHALL pass through a 2-FF synchronizer and a debounce counter; the press event is a one-cycle pulse on the debounced high-to-low transition, at most one pulse per physical press.
REQ-018 The FSM states SHALL be OFF, LIVE and FROZEN. Transitions:
- OFF + disp press -> LIVE.
- LIVE + disp press -> OFF.
- LIVE + hold press with count>0 -> FROZEN, hist_index=0.
- LIVE + hold press with count=0 -> ignored.
- FROZEN + hold press -> LIVE.
- FROZEN + disp press -> OFF.
REQ-019 A step press SHALL act only in FROZEN: hist_index = hist_index+1, wrapping to 0 after count-1.
REQ-020 If several press pulses occur in the same cycle, priority SHALL be disp > hold > step; the lower-priority pulses are discarded.
REQ-021 In OFF or LIVE, cpu_valid SHALL write {cpu_op_code, cpu_r16} at wr_ptr, increment wr_ptr modulo DEPTH, and increment count, saturating at DEPTH.
- At count=DEPTH the oldest entry is overwritten.
REQ-022 In FROZEN, cpu_valid SHALL NOT write the buffer and SHALL set lost.
REQ-023 lost SHALL be cleared on every transition into LIVE.
REQ-024 op_code/r16 SHALL be registered and SHALL show the entry at (wr_ptr-1-hist_index) mod DEPTH.
- In OFF/LIVE, hist_index is 0, so outputs update on the edge after the cpu_valid write: latency 1 cycle, pointer arithmetic on the post-write wr_ptr.
REQ-025 If cpu_valid and a hold press coincide in LIVE, the write SHALL complete first, and the frozen index-0 entry is the new entry.
REQ-026 enable SHALL be registered: 1 in LIVE and FROZEN, 0 in OFF.
- op_code/r16 keep tracking in OFF.
REQ-027 Before the first write (count=0), op_code and r16 SHALL hold their reset values.

Reset
REQ-028 On reset assertion, state SHALL go to OFF immediately, including mid-step or mid-debounce.
REQ-029 Reset values: enable=0, op_code=NOP, r16=0x00, frozen=0, hist_index=0, lost=0.
REQ-030 Reset SHALL clear wr_ptr, count, the debounce counters and the synchronizers (to released level 1); buffer contents need not be cleared.

Structure
REQ-031 The state enum (OFF, LIVE, FROZEN) and the NOP encoding SHALL come from package def; DEPTH and DEBOUNCE_CYCLES stay module parameters.
REQ-032 Debouncing SHALL live in one sub-module, key_debounce (clock, reset_s2_n, key_n, pressed), instantiated three times.

Verification (DEBOUNCE_CYCLES=4, DEPTH=8)
REQ-033 Reset, then disp press -> enable=1 after debounce; retire LDI/0x02 -> op_code=LDI, r16=0x02 one cycle after cpu_valid.
REQ-034 Disp press held low with 2-cycle bounce glitches -> exactly one press pulse, no toggle back.
REQ-035 Retire 10 instructions with r16=0x01..0x0A, hold press, then 8 step presses -> r16 shows 0x0A,0x09,...,0x03, then wraps to 0x0A; hist_index goes 0..7 then 0.
REQ-036 While frozen, retire r16=0x55 -> lost=1 and display unchanged; hold press -> LIVE, lost=0, display shows the previous newest entry (0x55 was dropped).
REQ-037 cpu_valid with r16=0x77 coincident with the hold pulse in LIVE -> frozen=1, hist_index=0, r16=0x77.
REQ-038 Assert reset while frozen at hist_index=3 -> all outputs at reset values asynchronously; a subsequent hold press with count=0 is ignored (frozen stays 0).
